// File: rtl/approx_adder_error_monitor_if.sv
// approx_adder_error_monitor_if: host/sample bus of the approximate-adder error monitor.
// Worst-case capture signals exist only when APPROX_MON_WORST_CASE_EN is defined.
interface approx_adder_error_monitor_if #(
    parameter int OP_W  = 16,
    parameter int SUM_W = OP_W + 1,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
);
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_a;
    logic [OP_W-1:0]  in_b;
    logic [SUM_W-1:0] in_approx;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_count;
    logic [CNT_W-1:0] err_count;
    logic [ACC_W-1:0] sum_abs_err;
    logic [SUM_W-1:0] max_abs_err;
`ifdef APPROX_MON_WORST_CASE_EN
    logic [OP_W-1:0]  wc_a;
    logic [OP_W-1:0]  wc_b;
    logic [SUM_W-1:0] wc_approx;
`endif

    modport master (
        output start, num_samples, in_valid, in_a, in_b, in_approx,
        input  in_ready, busy, done, sample_count, err_count, sum_abs_err, max_abs_err
`ifdef APPROX_MON_WORST_CASE_EN
        , input wc_a, wc_b, wc_approx
`endif
    );

    modport slave (
        input  start, num_samples, in_valid, in_a, in_b, in_approx,
        output in_ready, busy, done, sample_count, err_count, sum_abs_err, max_abs_err
`ifdef APPROX_MON_WORST_CASE_EN
        , output wc_a, wc_b, wc_approx
`endif
    );
endinterface

// File: rtl/approx_adder_error_monitor.sv
// approx_adder_error_monitor: accumulates error count, sum and max of |exact - approx| over a run.
// Define APPROX_MON_WORST_CASE_EN to also capture the operands of the first worst-case sample.
module approx_adder_error_monitor #(
    parameter int OP_W  = 16,
    parameter int SUM_W = OP_W + 1,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input logic clk,
    input logic rst,
    approx_adder_error_monitor_if.slave io_mon
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_num, r_accepted, r_cnt, r_err;
    logic             r_ready, r_v1, r_v2;
    logic [SUM_W-1:0] r_diff, r_max;
    logic [ACC_W-1:0] r_sum;
    logic             w_start, w_accept;
    logic [SUM_W-1:0] w_exact, w_abs;
    logic [SUM_W:0]   w_delta;
    logic [ACC_W:0]   w_sum_ext;
`ifdef APPROX_MON_WORST_CASE_EN
    logic [OP_W-1:0]  r_a1, r_b1, r_wc_a, r_wc_b;
    logic [SUM_W-1:0] r_ap1, r_wc_ap;
`endif

    always_comb begin
        w_start   = io_mon.start && (r_state == IDLE || r_state == DONE);
        w_accept  = io_mon.in_valid && r_ready;
        w_exact   = SUM_W'(io_mon.in_a) + SUM_W'(io_mon.in_b);
        w_delta   = {1'b0, w_exact} - {1'b0, io_mon.in_approx};
        w_abs     = w_delta[SUM_W] ? SUM_W'(-w_delta) : w_delta[SUM_W-1:0];
        w_sum_ext = {1'b0, r_sum} + (ACC_W+1)'(r_diff);
        w_next    = r_state;
        unique case (r_state)
            IDLE, DONE: w_next = w_start ? RUN : r_state;
            RUN:        w_next = (r_accepted == r_num) ? DRAIN : RUN;
            DRAIN:      w_next = (r_v1 || r_v2) ? DRAIN : DONE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_num      <= '0;
            r_accepted <= '0;
            r_ready    <= 1'b0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_diff     <= '0;
            r_cnt      <= '0;
            r_err      <= '0;
            r_sum      <= '0;
            r_max      <= '0;
        end else begin
            r_state <= w_next;
            r_v1    <= w_accept;
            r_v2    <= r_v1;
            // ready looks ahead one acceptance so it drops right after the last one
            r_ready <= w_start ? (io_mon.num_samples != '0)
                               : (r_state == RUN && (r_accepted + CNT_W'(w_accept)) < r_num);
            if (w_accept)
                r_diff <= w_abs;
            if (w_start) begin
                r_num      <= io_mon.num_samples;
                r_accepted <= '0;
                r_cnt      <= '0;
                r_err      <= '0;
                r_sum      <= '0;
                r_max      <= '0;
            end else begin
                if (w_accept)
                    r_accepted <= r_accepted + 1'b1;
                if (r_v1) begin
                    r_cnt <= r_cnt + 1'b1;
                    r_err <= r_err + CNT_W'(r_diff != '0);
                    r_sum <= w_sum_ext[ACC_W] ? '1 : w_sum_ext[ACC_W-1:0];
                    r_max <= (r_diff > r_max) ? r_diff : r_max;
                end
            end
        end
    end

`ifdef APPROX_MON_WORST_CASE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a1    <= '0;
            r_b1    <= '0;
            r_ap1   <= '0;
            r_wc_a  <= '0;
            r_wc_b  <= '0;
            r_wc_ap <= '0;
        end else begin
            if (w_accept) begin
                r_a1  <= io_mon.in_a;
                r_b1  <= io_mon.in_b;
                r_ap1 <= io_mon.in_approx;
            end
            if (w_start) begin
                r_wc_a  <= '0;
                r_wc_b  <= '0;
                r_wc_ap <= '0;
            end else if (r_v1 && r_diff > r_max) begin
                r_wc_a  <= r_a1;
                r_wc_b  <= r_b1;
                r_wc_ap <= r_ap1;
            end
        end
    end

    assign io_mon.wc_a      = r_wc_a;
    assign io_mon.wc_b      = r_wc_b;
    assign io_mon.wc_approx = r_wc_ap;
`endif

    assign io_mon.in_ready     = r_ready;
    assign io_mon.busy         = (r_state == RUN) || (r_state == DRAIN);
    assign io_mon.done         = (r_state == DONE);
    assign io_mon.sample_count = r_cnt;
    assign io_mon.err_count    = r_err;
    assign io_mon.sum_abs_err  = r_sum;
    assign io_mon.max_abs_err  = r_max;
endmodule

// File: doc/approx_adder_error_monitor.md
Name: approx_adder_error_monitor

Overview:
- Streaming error-evaluation block for the approximate-adder netlists: consumes operand pairs plus the approximate sum produced by a device under evaluation.
- Computes the exact sum internally and accumulates error metrics over a programmed number of samples: error count, sum of absolute error, maximum absolute error.
- Sits on the output side of an approximate adder in the evaluation harness; results are read by the host once done is asserted.

Parameters:
OP_W, 16, operand width in bits
SUM_W, OP_W+1, sum width (approximate and exact)
CNT_W, 32, width of the sample counters
ACC_W, 48, width of the absolute-error accumulator

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a run, sampled in IDLE or DONE only
num_samples  input  CNT_W  samples per run, latched on start
in_valid  input  1  sample valid
in_ready  output  1  sample accepted when in_valid && in_ready
in_a  input  OP_W  operand A
in_b  input  OP_W  operand B
in_approx  input  SUM_W  approximate sum from the DUT, bit SUM_W-1 = MSB
busy  output  1  high in RUN and DRAIN
done  output  1  high in DONE
sample_count  output  CNT_W  samples accumulated
err_count  output  CNT_W  samples with nonzero error
sum_abs_err  output  ACC_W  sum of |exact - approx|
max_abs_err  output  SUM_W  largest |exact - approx|

Behaviour:
- Reset: state IDLE; in_ready, busy, done = 0; all counters and accumulators = 0; pipeline valids = 0. Reset mid-run aborts the run; nothing is retained.
- States: IDLE -> (start) RUN; RUN -> (accepted == num_samples) DRAIN; DRAIN -> (both pipeline stages empty) DONE; DONE -> (start) RUN. start is ignored in RUN and DRAIN.
- On start: latch num_samples, clear all result registers and the accepted counter in the same cycle. If num_samples == 0, go RUN -> DRAIN -> DONE with all results 0 and no samples accepted.
- in_ready = (state == RUN) && (accepted < latched num_samples); registered, so it drops the cycle after the final acceptance. No backpressure is applied downstream; one sample per cycle is sustained.
- Stage 1 (registered): exact = in_a + in_b, zero-extended to SUM_W; diff = |exact - in_approx|, computed in SUM_W+1 bits, then truncated to SUM_W (result is never larger than 2^SUM_W-1).
- Stage 2 (registered): sample_count += 1; err_count += (diff != 0); sum_abs_err += diff, saturating at all-ones; max_abs_err = max(max_abs_err, diff).
- Latency: an accepted sample is reflected in the outputs 2 cycles after acceptance. DRAIN lasts at most 2 cycles.
- Counters CNT_W wide do not wrap: sample_count cannot exceed num_samples. Results hold stable in DONE until the next start.

Optional Feature:
- Macro: APPROX_MON_WORST_CASE_EN.
- Defined: adds outputs wc_a[OP_W], wc_b[OP_W] and wc_approx[SUM_W]. These hold the operands and approximate sum of the first sample that reached the current max_abs_err (strictly-greater update). They are cleared on start and on reset.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: hold rst 3 cycles -> all outputs 0, in_ready=0; in_valid=1 while IDLE is not accepted.
- Exact DUT: start with num_samples=4; send a=0x1234, b=0x0001, approx=0x01235 ×4 -> done; sample_count=4, err_count=0, sum_abs_err=0, max_abs_err=0.
- Errors: num_samples=3; samples (0xFFFF, 0x0001, approx 0x00000), (0x0003, 0x0004, 0x00007), (0x1234, 0x0001, 0x00000) -> err_count=2, sum_abs_err=0x11235, max_abs_err=0x10000; with APPROX_MON_WORST_CASE_EN, wc_a=0xFFFF.
- Throughput and latency: num_samples=8 with in_valid held high -> 8 consecutive accepts; in_ready low the cycle after the 8th accept; done 2–3 cycles later.
- Edge cases: num_samples=0 -> done with zero results and no accept; start pulsed during RUN is ignored; rst asserted mid-run -> IDLE with all outputs 0.
- Saturation: ACC_W=17 override; 3 samples each with error 0x10000 -> sum_abs_err=0x1FFFF.
